// File: rtl/timer_pkg.sv
// ============================================================================
// Module   : timer_pkg
// Brief    : Shared state encoding, default digit maxima and helpers for the
//            cascaded countdown timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // MM:SS, LSB digit first: 9 (s units), 5 (s tens), 9 (m units), 9 (m tens)
   localparam logic [15:0] c_DEFAULT_MAX_VEC = 16'h9959;

   // Widest packed maximum vector the helper accepts
   localparam int c_VEC_MAX_W = 256;

   function automatic logic [31:0] max_of(
      input logic [c_VEC_MAX_W-1:0] vec,
      input int                     i,
      input int                     w
   );
      logic [31:0] r;
      r = '0;
      for (int b = 0; b < w; b++) begin
         r[b] = vec[i*w + b];
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/timer_digit.sv
// ============================================================================
// Module   : timer_digit
// Brief    : One countdown digit with clamp-on-load and wrap-to-maximum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_digit #(
   parameter int                 DIGIT_W = 4,
   parameter logic [DIGIT_W-1:0] MAX     = DIGIT_W'(9)
) (
   input  logic               clk,
   input  logic               clear,
   input  logic               ld,
   input  logic [DIGIT_W-1:0] ld_val,
   input  logic               step,
   output logic [DIGIT_W-1:0] value,
   output logic               is_zero,
   output logic               clamped
);

   logic [DIGIT_W-1:0] r_value;
   logic [DIGIT_W-1:0] w_ld_sat;
   logic [DIGIT_W-1:0] w_dec;

   assign clamped  = (ld_val > MAX);
   assign w_ld_sat = clamped ? MAX : ld_val;
   assign w_dec    = (r_value == '0) ? MAX : (r_value - 1'b1);

   always_ff @(posedge clk) begin
      if (clear) begin
         r_value <= '0;
      end else if (ld) begin
         r_value <= w_ld_sat;
      end else if (step) begin
         r_value <= w_dec;
      end
   end

   assign value   = r_value;
   assign is_zero = (r_value == '0);

endmodule

`default_nettype wire

// File: rtl/timer_countdown_chain.sv
// ============================================================================
// Module   : timer_countdown_chain
// Brief    : N-digit cascaded down-counter with run/pause/done control and
//            optional auto-reload of the last loaded preset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_countdown_chain
   import timer_pkg::*;
#(
   parameter int                              NUM_DIGITS = 4,
   parameter int                              DIGIT_W    = 4,
   parameter logic [NUM_DIGITS*DIGIT_W-1:0]   MAX_VEC    =
      (NUM_DIGITS*DIGIT_W)'(c_DEFAULT_MAX_VEC)
) (
   input  logic                            clk,
   input  logic                            clear,
   input  logic                            load,
   input  logic [NUM_DIGITS*DIGIT_W-1:0]   load_value,
   input  logic                            start,
   input  logic                            pause,
   input  logic                            auto_reload,
   input  logic                            tick,
   output logic [NUM_DIGITS*DIGIT_W-1:0]   count,
   output logic                            zero,
   output logic [NUM_DIGITS-1:0]           terminal_count,
   output logic                            running,
   output logic                            done,
   output logic                            load_err
);

   localparam int c_TW = NUM_DIGITS * DIGIT_W;

   localparam logic [1:0] c_ST_IDLE  = IDLE;
   localparam logic [1:0] c_ST_RUN   = RUN;
   localparam logic [1:0] c_ST_PAUSE = PAUSE;
   localparam logic [1:0] c_ST_DONE  = DONE;

   localparam logic [c_VEC_MAX_W-1:0] c_MAX_VEC_EXT = c_VEC_MAX_W'(MAX_VEC);

   logic [1:0]            r_state;
   logic [c_TW-1:0]       r_reload;
   logic                  r_done;
   logic                  r_load_err;

   logic [NUM_DIGITS-1:0] w_is_zero;
   logic [NUM_DIGITS-1:0] w_clamped;
   logic [NUM_DIGITS-1:0] w_low_zero;
   logic [NUM_DIGITS-1:0] w_step;
   logic [c_TW-1:0]       w_ld_sat;
   logic [c_TW-1:0]       w_digit_ld_val;
   logic                  w_run;
   logic                  w_zero;
   logic                  w_dec;
   logic                  w_last;
   logic                  w_reload;
   logic                  w_digit_ld;

   assign w_run  = (r_state == c_ST_RUN);
   assign w_zero = &w_is_zero;

   // A step is suppressed by any higher-priority control input this cycle
   assign w_dec  = w_run & tick & ~load & ~pause & ~w_zero;

   // count == 1 is the only value whose decrement lands on zero
   assign w_last     = w_dec & (count == c_TW'(1));
   assign w_reload   = w_last & auto_reload & (r_reload != '0);
   assign w_digit_ld = load | w_reload;
   assign w_digit_ld_val = load ? load_value : r_reload;

   generate
      for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
         localparam logic [DIGIT_W-1:0] c_MAX =
            DIGIT_W'(max_of(c_MAX_VEC_EXT, i, DIGIT_W));

         if (i == 0) begin : g_lsb
            assign w_low_zero[i] = 1'b1;
         end else begin : g_upper
            assign w_low_zero[i] = w_low_zero[i-1] & w_is_zero[i-1];
         end

         assign w_step[i]         = w_dec & w_low_zero[i];
         assign terminal_count[i] = w_run & tick & w_low_zero[i] & w_is_zero[i];
         assign w_ld_sat[i*DIGIT_W +: DIGIT_W] =
            w_clamped[i] ? c_MAX : load_value[i*DIGIT_W +: DIGIT_W];

         timer_digit #(
            .DIGIT_W (DIGIT_W),
            .MAX     (c_MAX)
         ) u_digit (
            .clk     (clk),
            .clear   (clear),
            .ld      (w_digit_ld),
            .ld_val  (w_digit_ld_val[i*DIGIT_W +: DIGIT_W]),
            .step    (w_step[i]),
            .value   (count[i*DIGIT_W +: DIGIT_W]),
            .is_zero (w_is_zero[i]),
            .clamped (w_clamped[i])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (clear) begin
         r_state    <= c_ST_IDLE;
         r_reload   <= '0;
         r_done     <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_done     <= w_last;
         r_load_err <= load & (|w_clamped);
         if (load) begin
            r_reload <= w_ld_sat;
            r_state  <= c_ST_IDLE;
         end else begin
            case (r_state)
               c_ST_RUN: begin
                  if (pause) begin
                     r_state <= c_ST_PAUSE;
                  end else if (w_last && !w_reload) begin
                     r_state <= c_ST_DONE;
                  end
               end
               c_ST_IDLE, c_ST_PAUSE: begin
                  if (!pause && start && !w_zero) begin
                     r_state <= c_ST_RUN;
                  end
               end
               default: begin
                  r_state <= c_ST_DONE;
               end
            endcase
         end
      end
   end

   assign zero     = w_zero;
   assign running  = w_run;
   assign done     = r_done;
   assign load_err = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_timer_countdown_chain.sv
// ============================================================================
// Module   : tb_timer_countdown_chain
// Brief    : Directed plus randomized bench against an integer-seconds model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_countdown_chain;

   localparam int ND = 4;
   localparam int DW = 4;
   localparam int TW = ND * DW;
   localparam int c_MOD [ND] = '{10, 6, 10, 10};

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic          clk = 1'b0;
   logic          clear, load, start, pause, auto_reload, tick;
   logic [TW-1:0] load_value;
   logic [TW-1:0] count;
   logic          zero, running, done, load_err;
   logic [ND-1:0] terminal_count;

   int n_vec = 0;
   int n_err = 0;

   // model: count kept as a plain number of base units
   int m_total = 0;
   int m_rel   = 0;
   int m_st    = M_IDLE;
   bit m_done  = 1'b0;
   bit m_lerr  = 1'b0;
   logic [ND-1:0] tc_seen;

   timer_countdown_chain dut (
      .clk            (clk),
      .clear          (clear),
      .load           (load),
      .load_value     (load_value),
      .start          (start),
      .pause          (pause),
      .auto_reload    (auto_reload),
      .tick           (tick),
      .count          (count),
      .zero           (zero),
      .terminal_count (terminal_count),
      .running        (running),
      .done           (done),
      .load_err       (load_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [TW-1:0] to_digits(input int total);
      logic [TW-1:0] r;
      int t;
      t = total;
      r = '0;
      for (int i = 0; i < ND; i++) begin
         r[i*DW +: DW] = DW'(t % c_MOD[i]);
         t = t / c_MOD[i];
      end
      return r;
   endfunction

   task automatic model_step(input bit c, input bit l, input logic [TW-1:0] lv,
                             input bit s, input bit p, input bit ar, input bit t);
      int w;
      int d;
      m_done = 1'b0;
      m_lerr = 1'b0;
      if (c) begin
         m_total = 0;
         m_rel   = 0;
         m_st    = M_IDLE;
      end else if (l) begin
         m_total = 0;
         w = 1;
         for (int i = 0; i < ND; i++) begin
            d = int'(lv[i*DW +: DW]);
            if (d > c_MOD[i] - 1) begin
               d = c_MOD[i] - 1;
               m_lerr = 1'b1;
            end
            m_total += d * w;
            w *= c_MOD[i];
         end
         m_rel = m_total;
         m_st  = M_IDLE;
      end else if (p) begin
         if (m_st == M_RUN) m_st = M_PAUSE;
      end else if (s && (m_st == M_IDLE || m_st == M_PAUSE) && m_total != 0) begin
         m_st = M_RUN;
      end else if (m_st == M_RUN && t && m_total != 0) begin
         m_total--;
         if (m_total == 0) begin
            m_done = 1'b1;
            if (ar && m_rel != 0) m_total = m_rel;
            else m_st = M_DONE;
         end
      end
   endtask

   task automatic cyc(input bit c, input bit l, input logic [TW-1:0] lv,
                      input bit s, input bit p, input bit ar, input bit t);
      int prod;
      logic [ND-1:0] exp_tc;
      @(negedge clk);
      clear = c; load = l; load_value = lv;
      start = s; pause = p; auto_reload = ar; tick = t;
      #1;
      prod = 1;
      for (int i = 0; i < ND; i++) begin
         prod *= c_MOD[i];
         exp_tc[i] = (m_st == M_RUN) && t && (m_total % prod == 0);
      end
      tc_seen = terminal_count;
      check("terminal_count", 32'(terminal_count), 32'(exp_tc));
      model_step(c, l, lv, s, p, ar, t);
      @(posedge clk);
      #1;
      check("count",    32'(count),    32'(to_digits(m_total)));
      check("zero",     32'(zero),     32'(m_total == 0));
      check("running",  32'(running),  32'(m_st == M_RUN));
      check("done",     32'(done),     32'(m_done));
      check("load_err", 32'(load_err), 32'(m_lerr));
   endtask

   initial begin
      bit c, l, s, p, ar, t;
      logic [TW-1:0] lv;
      clear = 1'b0; load = 1'b0; load_value = '0; start = 1'b0;
      pause = 1'b0; auto_reload = 1'b0; tick = 1'b0;

      cyc(1, 0, '0, 0, 0, 0, 0);
      cyc(1, 0, '0, 0, 0, 0, 0);
      check("rst_count", 32'(count), 32'h0);
      check("rst_running", 32'(running), 32'h0);

      // 01:30 runs down to zero
      cyc(0, 1, 16'h0130, 0, 0, 0, 0);
      cyc(0, 0, '0, 1, 0, 0, 0);
      cyc(0, 0, '0, 0, 0, 0, 1);
      check("dir_0129", 32'(count), 32'h0129);
      check("dir_run", 32'(running), 32'h1);
      repeat (89) cyc(0, 0, '0, 0, 0, 0, 1);
      check("dir_end_count", 32'(count), 32'h0);
      check("dir_end_done", 32'(done), 32'h1);
      cyc(0, 0, '0, 1, 0, 0, 1);
      check("dir_done_once", 32'(done), 32'h0);
      check("dir_done_stop", 32'(running), 32'h0);

      // borrow through three digits
      cyc(0, 1, 16'h1000, 0, 0, 0, 0);
      cyc(0, 0, '0, 1, 0, 0, 0);
      cyc(0, 0, '0, 0, 0, 0, 1);
      check("dir_tc", 32'(tc_seen), 32'h7);
      check("dir_0959", 32'(count), 32'h0959);

      // clamp and start-at-zero
      cyc(0, 1, 16'h0199, 0, 0, 0, 0);
      check("dir_clamp", 32'(count), 32'h0159);
      check("dir_lerr", 32'(load_err), 32'h1);
      cyc(0, 0, '0, 0, 0, 0, 0);
      check("dir_lerr_pulse", 32'(load_err), 32'h0);
      cyc(0, 1, 16'h0000, 0, 0, 0, 0);
      cyc(0, 0, '0, 1, 0, 0, 0);
      check("dir_zero_start", 32'(running), 32'h0);

      // pause / resume
      cyc(0, 1, 16'h0005, 0, 0, 0, 0);
      cyc(0, 0, '0, 1, 0, 0, 0);
      repeat (3) cyc(0, 0, '0, 0, 1, 0, 1);
      check("dir_pause_hold", 32'(count), 32'h0005);
      cyc(0, 0, '0, 1, 0, 0, 0);
      cyc(0, 0, '0, 0, 0, 0, 1);
      check("dir_resume", 32'(count), 32'h0004);
      cyc(0, 0, '0, 1, 1, 0, 1);
      check("dir_pause_wins", 32'(running), 32'h0);

      // auto-reload
      cyc(0, 1, 16'h0002, 0, 0, 1, 0);
      cyc(0, 0, '0, 1, 0, 1, 0);
      cyc(0, 0, '0, 0, 0, 1, 1);
      check("dir_ar_1", 32'(count), 32'h0001);
      cyc(0, 0, '0, 0, 0, 1, 1);
      check("dir_ar_reload", 32'(count), 32'h0002);
      check("dir_ar_done", 32'(done), 32'h1);
      cyc(0, 0, '0, 0, 0, 1, 1);
      check("dir_ar_again", 32'(count), 32'h0001);
      check("dir_ar_run", 32'(running), 32'h1);

      // clear beats load and a zero-reaching tick
      cyc(1, 1, 16'h0777, 0, 0, 1, 1);
      check("dir_clr_count", 32'(count), 32'h0);
      check("dir_clr_done", 32'(done), 32'h0);
      check("dir_clr_lerr", 32'(load_err), 32'h0);

      ar = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         c  = ($urandom_range(0, 99) < 2);
         l  = ($urandom_range(0, 99) < 6);
         s  = ($urandom_range(0, 99) < 40);
         p  = ($urandom_range(0, 99) < 12);
         t  = ($urandom_range(0, 99) < 60);
         if ($urandom_range(0, 99) < 3) ar = ~ar;
         case ($urandom_range(0, 3))
            0:       lv = TW'($urandom);
            1:       lv = TW'($urandom_range(0, 15));
            2:       lv = TW'($urandom_range(0, 16'h0130));
            default: lv = 16'h0010 | TW'($urandom_range(0, 9));
         endcase
         cyc(c, l, lv, s, p, ar, t);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
